mem_stage: RTL and testbench

- Pipeline MEM stage between AGEX and WB.
- Performs data-memory loads and stores against an internal word-addressed DMEM array, with optional extra load wait-states.
- Registers results into the MEM latch consumed by WB; ALU results pass through unchanged.
- Exports destination-register info to DE for hazard detection, and a stall signal to AGEX/DE.

---
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: internal word-addressed DMEM, sized loads/stores, optional load wait-states.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and expose o_mem_misalign.
module mem_stage #(
    parameter int DBITS      = 32,
    parameter int IOPBITS    = 6,
    parameter int DMEM_WORDS = 1024,
    parameter int LOAD_LAT   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_agex_valid,
    input  logic [31:0]        i_agex_inst,
    input  logic [DBITS-1:0]   i_agex_pc,
    input  logic [IOPBITS-1:0] i_agex_op,
    input  logic [DBITS-1:0]   i_agex_inst_count,
    input  logic               i_agex_is_load,
    input  logic               i_agex_is_store,
    input  logic               i_agex_wr_reg,
    input  logic [DBITS-1:0]   i_agex_memaddr,
    input  logic [DBITS-1:0]   i_agex_st_data,
    input  logic [DBITS-1:0]   i_agex_regval,
    output logic               o_mem_stall,
    output logic               o_mem_valid,
    output logic [31:0]        o_mem_inst,
    output logic [DBITS-1:0]   o_mem_pc,
    output logic [IOPBITS-1:0] o_mem_op,
    output logic [DBITS-1:0]   o_mem_inst_count,
    output logic               o_mem_wr_reg,
    output logic [4:0]         o_mem_wregno,
    output logic [DBITS-1:0]   o_mem_regval,
    output logic               o_to_de_wr_reg,
    output logic [4:0]         o_to_de_wregno
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic               o_mem_misalign
`endif
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam logic [3:0] LAT_INIT = (LOAD_LAT > 0) ? 4'(LOAD_LAT - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state, w_state_next;
    logic [3:0]         r_cnt, w_cnt_next;
    logic [DBITS-1:0]   r_dmem [DMEM_WORDS];
    logic [AW-1:0]      w_idx;
    logic [2:0]         w_f3;
    logic [DBITS-1:0]   w_rdata, w_load_data, w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [3:0]         w_be;
    logic               w_misalign, w_load, w_stall, w_store_we;
    logic               w_unused;

    assign w_idx    = i_agex_memaddr[AW+1:2];
    assign w_f3     = i_agex_inst[14:12];
    assign w_rdata  = r_dmem[w_idx];
    assign w_byte   = w_rdata[{i_agex_memaddr[1:0], 3'b000} +: 8];
    assign w_half   = w_rdata[{i_agex_memaddr[1], 4'b0000} +: 16];
    assign w_unused = ^i_agex_memaddr[DBITS-1:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = i_agex_valid & (i_agex_is_load | i_agex_is_store) &
                        (((w_f3[1:0] == 2'b01) & i_agex_memaddr[0]) |
                         ((w_f3[1:0] == 2'b10) & (i_agex_memaddr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        case (w_f3)
            3'b000:  w_load_data = {{(DBITS-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DBITS-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DBITS-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DBITS-16){1'b0}}, w_half};
            default: w_load_data = w_rdata;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_agex_st_data;
        case (w_f3)
            3'b000: begin
                w_be    = 4'b0001 << i_agex_memaddr[1:0];
                w_wdata = {4{i_agex_st_data[7:0]}};
            end
            3'b001: begin
                w_be    = i_agex_memaddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_agex_st_data[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_store_we = i_rst_n & i_agex_valid & i_agex_is_store & (r_state == S_IDLE) & ~w_misalign;

    always_ff @(posedge i_clk) begin
        if (w_store_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_dmem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_load = i_agex_valid & i_agex_is_load & ~w_misalign;

    // w_stall doubles as the bubble indicator for the MEM latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load && (LOAD_LAT != 0)) begin
                    w_stall      = 1'b1;
                    w_state_next = S_WAIT;
                    w_cnt_next   = LAT_INIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_valid      <= 1'b0;
            o_mem_wr_reg     <= 1'b0;
            o_mem_inst       <= '0;
            o_mem_pc         <= '0;
            o_mem_op         <= '0;
            o_mem_inst_count <= '0;
            o_mem_regval     <= '0;
        end else begin
            o_mem_valid      <= i_agex_valid & ~w_stall;
            o_mem_wr_reg     <= i_agex_valid & ~w_stall & i_agex_wr_reg & ~i_agex_is_store & ~w_misalign;
            o_mem_inst       <= i_agex_inst;
            o_mem_pc         <= i_agex_pc;
            o_mem_op         <= i_agex_op;
            o_mem_inst_count <= i_agex_inst_count;
            o_mem_regval     <= i_agex_is_load ? w_load_data : i_agex_regval;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_mem_misalign <= 1'b0;
        else          o_mem_misalign <= i_agex_valid & ~w_stall & w_misalign;
    end
`endif

    assign o_mem_wregno   = o_mem_inst[11:7];
    assign o_mem_stall    = w_stall & i_rst_n;
    assign o_to_de_wr_reg = i_agex_valid & i_agex_wr_reg;
    assign o_to_de_wregno = i_agex_inst[11:7];
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a LOAD_LAT=0 instance and a LOAD_LAT=3 instance share stimulus.
// Expected writeback values are queued when an instruction is driven and popped when it retires.
module tb_mem_stage;
    localparam int DBITS   = 32;
    localparam int IOPBITS = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, en3;
    logic               valid, is_load, is_store, wr_reg;
    logic [31:0]        inst;
    logic [DBITS-1:0]   pc, inst_count, memaddr, st_data, regval;
    logic [IOPBITS-1:0] op;
    logic               valid3;
    assign valid3 = valid & en3;

    logic               o0_stall, o0_valid, o0_wr_reg, o0_de_wr;
    logic [31:0]        o0_inst;
    logic [DBITS-1:0]   o0_pc, o0_cnt, o0_regval;
    logic [IOPBITS-1:0] o0_op;
    logic [4:0]         o0_wregno, o0_de_wregno;
    logic               o3_stall, o3_valid, o3_wr_reg, o3_de_wr;
    logic [31:0]        o3_inst;
    logic [DBITS-1:0]   o3_pc, o3_cnt, o3_regval;
    logic [IOPBITS-1:0] o3_op;
    logic [4:0]         o3_wregno, o3_de_wregno;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               o0_misalign, o3_misalign;
`endif

    mem_stage #(.DBITS(DBITS), .IOPBITS(IOPBITS), .DMEM_WORDS(1024), .LOAD_LAT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_agex_valid(valid), .i_agex_inst(inst),
        .i_agex_pc(pc), .i_agex_op(op), .i_agex_inst_count(inst_count),
        .i_agex_is_load(is_load), .i_agex_is_store(is_store), .i_agex_wr_reg(wr_reg),
        .i_agex_memaddr(memaddr), .i_agex_st_data(st_data), .i_agex_regval(regval),
        .o_mem_stall(o0_stall), .o_mem_valid(o0_valid), .o_mem_inst(o0_inst),
        .o_mem_pc(o0_pc), .o_mem_op(o0_op), .o_mem_inst_count(o0_cnt),
        .o_mem_wr_reg(o0_wr_reg), .o_mem_wregno(o0_wregno), .o_mem_regval(o0_regval),
        .o_to_de_wr_reg(o0_de_wr), .o_to_de_wregno(o0_de_wregno)
`ifdef MEM_MISALIGN_TRAP_EN
        , .o_mem_misalign(o0_misalign)
`endif
    );

    mem_stage #(.DBITS(DBITS), .IOPBITS(IOPBITS), .DMEM_WORDS(1024), .LOAD_LAT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_agex_valid(valid3), .i_agex_inst(inst),
        .i_agex_pc(pc), .i_agex_op(op), .i_agex_inst_count(inst_count),
        .i_agex_is_load(is_load), .i_agex_is_store(is_store), .i_agex_wr_reg(wr_reg),
        .i_agex_memaddr(memaddr), .i_agex_st_data(st_data), .i_agex_regval(regval),
        .o_mem_stall(o3_stall), .o_mem_valid(o3_valid), .o_mem_inst(o3_inst),
        .o_mem_pc(o3_pc), .o_mem_op(o3_op), .o_mem_inst_count(o3_cnt),
        .o_mem_wr_reg(o3_wr_reg), .o_mem_wregno(o3_wregno), .o_mem_regval(o3_regval),
        .o_to_de_wr_reg(o3_de_wr), .o_to_de_wregno(o3_de_wregno)
`ifdef MEM_MISALIGN_TRAP_EN
        , .o_mem_misalign(o3_misalign)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    task automatic drive(input logic ld, input logic st, input logic wr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rv);
        @(negedge clk);
        valid      = 1'b1;
        is_load    = ld;
        is_store   = st;
        wr_reg     = wr;
        inst       = {17'h0, f3, rd, ld ? 7'h03 : (st ? 7'h23 : 7'h13)};
        pc         = pc + 32'd4;
        inst_count = inst_count + 32'd1;
        memaddr    = addr;
        st_data    = sd;
        regval     = rv;
        $display("drive: ld=%0b st=%0b f3=%0d rd=%0d addr=%h sd=%h rv=%h", ld, st, f3, rd, addr, sd, rv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en3 = 1'b1;
        valid = 1'b1; is_load = 1'b1; is_store = 1'b0; wr_reg = 1'b1;
        inst = {17'h0, 3'b010, 5'd4, 7'h03}; pc = 32'h100; inst_count = 0; op = 6'd3;
        memaddr = 32'h40; st_data = 0; regval = 32'h5555;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (o0_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o0_valid); else n_pass++;
        n_total++; if (o0_wr_reg !== 1'b0) $display("FAIL reset_wr_reg: got %b want 0", o0_wr_reg); else n_pass++;
        n_total++; if (o0_regval !== 32'h0) $display("FAIL reset_regval: got %h want 0", o0_regval); else n_pass++;
        n_total++; if (o0_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", o0_pc); else n_pass++;
        n_total++; if (o3_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o3_stall); else n_pass++;
        @(negedge clk);
        valid = 1'b0; en3 = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h40, 32'hDEADBEEF, 32'h0);
        @(posedge clk); #1;
        n_total++; if (o0_valid !== 1'b1) $display("FAIL sw_valid: got %b want 1", o0_valid); else n_pass++;
        n_total++; if (o0_wr_reg !== 1'b0) $display("FAIL sw_wr_reg: got %b want 0", o0_wr_reg); else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd5, 32'h40, 32'h0, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        n_total++; if (o0_stall !== 1'b0) $display("FAIL lw_stall: got %b want 0", o0_stall); else n_pass++;
        n_total++; if (o0_de_wregno !== 5'd5 || o0_de_wr !== 1'b1)
            $display("FAIL lw_to_de: got %0d/%b want 5/1", o0_de_wregno, o0_de_wr); else n_pass++;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o0_valid !== 1'b1 || o0_wr_reg !== 1'b1)
            $display("FAIL lw_valid: got %b/%b want 1/1", o0_valid, o0_wr_reg); else n_pass++;
        n_total++; if (o0_regval !== e) $display("FAIL lw_data: got %h want %h", o0_regval, e); else n_pass++;
        n_total++; if (o0_wregno !== 5'd5) $display("FAIL lw_wregno: got %0d want 5", o0_wregno); else n_pass++;
    endtask

    task automatic test_load_sizes();
        logic [2:0]  f3s [5];
        logic [31:0] adr [5];
        logic [31:0] exs [5];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        adr = '{32'h43, 32'h43, 32'h42, 32'h40, 32'h1040};
        exs = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hDEADBEEF};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, f3s[i], 5'(i + 1), adr[i], 32'h0, 32'h0);
            exp_q.push_back(exs[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_total++; if (o0_valid !== 1'b1) $display("FAIL size%0d_valid: got %b want 1", i, o0_valid); else n_pass++;
            n_total++; if (o0_regval !== e) $display("FAIL size%0d_data: got %h want %h", i, o0_regval, e); else n_pass++;
        end
    endtask

    task automatic test_sub_store();
        drive(1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h41, 32'hFFFFFF11, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h40, 32'h0, 32'h0);
        exp_q.push_back(32'hDEAD11EF);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o0_regval !== e || o0_valid !== 1'b1)
            $display("FAIL sb_merge: got %h/%b want %h/1", o0_regval, o0_valid, e); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h42, 32'h7777ABCD, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h40, 32'h0, 32'h0);
        exp_q.push_back(32'hABCD11EF);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o0_regval !== e) $display("FAIL sh_merge: got %h want %h", o0_regval, e); else n_pass++;
    endtask

    task automatic test_alu_and_bubble();
        drive(1'b0, 1'b0, 1'b1, 3'b000, 5'd9, 32'h40, 32'h0, 32'h00001234);
        exp_q.push_back(32'h00001234);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o0_regval !== e) $display("FAIL alu_regval: got %h want %h", o0_regval, e); else n_pass++;
        n_total++; if (o0_wr_reg !== 1'b1 || o0_wregno !== 5'd9)
            $display("FAIL alu_wr: got %b/%0d want 1/9", o0_wr_reg, o0_wregno); else n_pass++;
        @(negedge clk);
        valid = 1'b0;
        #1;
        n_total++; if (o0_de_wr !== 1'b0) $display("FAIL bubble_to_de: got %b want 0", o0_de_wr); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (o0_valid !== 1'b0 || o0_wr_reg !== 1'b0)
            $display("FAIL bubble_latch: got %b/%b want 0/0", o0_valid, o0_wr_reg); else n_pass++;
    endtask

    task automatic test_load_lat();
        en3 = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h80, 32'hCAFEF00D, 32'h0);
        #1;
        n_total++; if (o3_stall !== 1'b0) $display("FAIL lat_store_stall: got %b want 0", o3_stall); else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd7, 32'h80, 32'h0, 32'h0);
        exp_q.push_back(32'hCAFEF00D);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++; if (o3_stall !== (c < 3))
                $display("FAIL lat_stall_c%0d: got %b want %b", c, o3_stall, (c < 3)); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (o3_valid !== (c == 3))
                $display("FAIL lat_valid_c%0d: got %b want %b", c, o3_valid, (c == 3)); else n_pass++;
            if (c == 3) begin
                e = exp_q.pop_front();
                n_total++; if (o3_regval !== e) $display("FAIL lat_data: got %h want %h", o3_regval, e); else n_pass++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h80, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (o3_valid !== 1'b0) $display("FAIL rst_wait_valid: got %b want 0", o3_valid); else n_pass++;
        n_total++; if (o3_stall !== 1'b0) $display("FAIL rst_wait_stall: got %b want 0", o3_stall); else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 3'b000, 5'd3, 32'h0, 32'h0, 32'h0000ABCD);
        rst_n = 1'b1;
        exp_q.push_back(32'h0000ABCD);
        #1;
        n_total++; if (o3_stall !== 1'b0) $display("FAIL rst_addi_stall: got %b want 0", o3_stall); else n_pass++;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o3_valid !== 1'b1 || o3_wr_reg !== 1'b1)
            $display("FAIL rst_addi_valid: got %b/%b want 1/1", o3_valid, o3_wr_reg); else n_pass++;
        n_total++; if (o3_regval !== e) $display("FAIL rst_addi_regval: got %h want %h", o3_regval, e); else n_pass++;
        @(negedge clk);
        valid = 1'b0; en3 = 1'b0;
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h42, 32'h12345678, 32'h0);
        @(posedge clk); #1;
`ifdef MEM_MISALIGN_TRAP_EN
        n_total++; if (o0_misalign !== 1'b1) $display("FAIL mis_flag: got %b want 1", o0_misalign); else n_pass++;
        exp_q.push_back(32'hABCD11EF);
`else
        exp_q.push_back(32'h12345678);
`endif
        drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd10, 32'h40, 32'h0, 32'h0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_total++; if (o0_regval !== e) $display("FAIL mis_word: got %h want %h", o0_regval, e); else n_pass++;
        drive(1'b1, 1'b0, 1'b1, 3'b001, 5'd11, 32'h43, 32'h0, 32'h0);
        @(posedge clk); #1;
`ifdef MEM_MISALIGN_TRAP_EN
        n_total++; if (o0_wr_reg !== 1'b0 || o0_misalign !== 1'b1)
            $display("FAIL mis_lh: got %b/%b want 0/1", o0_wr_reg, o0_misalign); else n_pass++;
`else
        n_total++; if (o0_regval !== 32'h00001234 || o0_wr_reg !== 1'b1)
            $display("FAIL lh_lowbit: got %h/%b want 00001234/1", o0_regval, o0_wr_reg); else n_pass++;
`endif
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_sizes();
        test_sub_store();
        test_alu_and_bubble();
        test_load_lat();
        test_reset_wait();
        test_misalign();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
